// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control sequencer: walks fetch/decode/execute/memory/writeback
// states and decodes the datapath control strobes from the current state.
module multicycle_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Opcode,
  input  logic        mem_ready,
  input  logic        stall,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8,
    IMM_EXEC = 4'd9
  } state_t;

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t      state_reg, state_next;
  logic [31:0] count_reg;
  logic        retire;

  // Next-state logic; retire marks the final step of a completed instruction.
  always_comb begin
    state_next = FETCH;
    retire     = 1'b0;
    case (state_reg)
      FETCH:    state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Opcode)
          OP_LD, OP_SD: state_next = MEM_ADDR;
          OP_RTYP:      state_next = EXEC;
          OP_ADDI:      state_next = IMM_EXEC;
          OP_BEQ:       state_next = BRANCH;
          default:      state_next = FETCH;
        endcase
      end
      MEM_ADDR: begin
        if (Opcode == OP_LD)      state_next = MEM_RD;
        else if (Opcode == OP_SD) state_next = MEM_WR;
        else                      state_next = FETCH;
      end
      MEM_RD:   state_next = mem_ready ? MEM_WB : MEM_RD;
      MEM_WB: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      MEM_WR: begin
        if (mem_ready) begin
          state_next = FETCH;
          retire     = 1'b1;
        end else begin
          state_next = MEM_WR;
        end
      end
      EXEC:     state_next = ALU_WB;
      IMM_EXEC: state_next = ALU_WB;
      ALU_WB: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      BRANCH: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      default:  state_next = FETCH;
    endcase
  end

  // Stall freezes both the sequencer and the retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FETCH;
      count_reg <= 32'd0;
    end else if (!stall) begin
      state_reg <= state_next;
      if (retire)
        count_reg <= count_reg + 32'd1;
    end
  end

  // Control decode; strobes are gated by stall, mux selects are not.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;
    case (state_reg)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !(Opcode inside {OP_LD, OP_SD, OP_RTYP, OP_ADDI, OP_BEQ});
      end
      MEM_ADDR, IMM_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALU_WB:   RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      default: ;
    endcase
    if (stall) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      illegal_op  = 1'b0;
    end
  end

  assign state       = state_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: an instruction-path model pushes
// per-cycle expectations; a negedge monitor pops and compares them.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  Opcode = 7'd0;
  logic        mem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite;
  logic        IRWrite, MemtoReg, RegWrite, ALUSrcA, illegal_op;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic [31:0] instr_count;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready), .stall(stall),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LD = 7'b0000011, SD = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] AI = 7'b0010011, BQ = 7'b1100011, BAD = 7'b1111111;

  typedef struct packed {
    logic pcw, pcwc, pcsrc, iord, mrd, mwr, irw, m2r, rw, srca;
    logic [1:0] srcb, aluop;
    logic ill;
  } ctl_t;

  typedef struct {
    int          st;
    ctl_t        ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  ctl_t        dut_ctl;

  // Instruction model: the state path an instruction walks, and a step index.
  int          path[$];
  int          pos = 0;
  logic [31:0] m_cnt = 32'd0;
  logic [6:0]  cur_op = 7'd0;

  assign dut_ctl = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op};

  function automatic void build_path(input logic [6:0] op);
    case (op)
      LD:      path = {0, 1, 2, 3, 4};
      SD:      path = {0, 1, 2, 5};
      RT:      path = {0, 1, 6, 7};
      AI:      path = {0, 1, 9, 7};
      BQ:      path = {0, 1, 8};
      default: path = {0, 1};
    endcase
  endfunction

  function automatic int cur_st();
    if (pos == 0) return 0;
    if (pos == 1) return 1;
    return path[pos];
  endfunction

  // Expected control word for a state, straight from the per-state output list.
  function automatic ctl_t ctl_of(input int st, input logic mr, input logic stl, input logic ill);
    ctl_t c;
    c = '0;
    case (st)
      0: begin c.mrd = 1'b1; c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
      1: begin c.srcb = 2'b11; c.ill = ill; end
      2: begin c.srca = 1'b1; c.srcb = 2'b10; end
      3: begin c.mrd = 1'b1; c.iord = 1'b1; end
      4: begin c.rw = 1'b1; c.m2r = 1'b1; end
      5: begin c.mwr = 1'b1; c.iord = 1'b1; end
      6: begin c.srca = 1'b1; c.aluop = 2'b10; end
      7: c.rw = 1'b1;
      8: begin c.srca = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 1'b1; end
      9: begin c.srca = 1'b1; c.srcb = 2'b10; end
      default: ;
    endcase
    if (stl) begin
      c.pcw = 1'b0; c.pcwc = 1'b0; c.irw = 1'b0; c.mrd = 1'b0;
      c.mwr = 1'b0; c.rw = 1'b0; c.ill = 1'b0;
    end
    return c;
  endfunction

  // One clock of stimulus: drive inputs, push the expectation, advance the model.
  task automatic cycle(input logic [6:0] op, input logic mr, input logic st);
    int   s;
    exp_t e;
    @(posedge clk);
    #1;
    Opcode = op; mem_ready = mr; stall = st;
    s = cur_st();
    if (s == 1) build_path(op);
    e.st  = s;
    e.ctl = ctl_of(s, mr, st, (s == 1) && (path.size() == 2));
    e.cnt = m_cnt;
    exp_q.push_back(e);
    if (!st && !((s == 0 || s == 3 || s == 5) && !mr)) begin
      if (s == 0) begin
        pos = 1;
      end else begin
        pos++;
        if (pos >= path.size()) begin
          pos = 0;
          if (path.size() > 2) begin
            m_cnt = m_cnt + 32'd1;
            $display("retire #%0d opcode=%b path_len=%0d", m_cnt, op, path.size());
          end else begin
            $display("dropped illegal opcode=%b", op);
          end
        end
      end
    end
  endtask

  task automatic run(input logic [6:0] op, input int n);
    for (int i = 0; i < n; i++) cycle(op, 1'b1, 1'b0);
  endtask

  function automatic logic [6:0] pick_op();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1:    return LD;
      2:       return SD;
      3, 4:    return RT;
      5:       return AI;
      6, 7:    return BQ;
      8:       return BAD;
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: outputs are combinational and settled by the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("ctl", 32'(dut_ctl), 32'(e.ctl));
        chk("instr_count", instr_count, e.cnt);
      end
    end
  end

  initial begin : stim
    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_count", instr_count, 32'd0);
    chk("reset_ctl", 32'(dut_ctl), 32'(ctl_of(0, 1'b0, 1'b0, 1'b0)));
    #10 reset = 1'b0;

    // Directed paths with memory always ready.
    run(RT, 4);
    run(LD, 5);
    run(SD, 4);
    run(BQ, 3);
    run(AI, 4);
    // Three-cycle memory wait in MEM_RD.
    run(LD, 3);
    for (int i = 0; i < 3; i++) cycle(LD, 1'b0, 1'b0);
    run(LD, 2);
    // Illegal opcode in DECODE.
    run(BAD, 2);
    // Two-cycle stall in ALU_WB.
    run(RT, 3);
    cycle(RT, 1'b1, 1'b1);
    cycle(RT, 1'b1, 1'b1);
    cycle(RT, 1'b1, 1'b0);

    // Reset between edges while waiting in MEM_WR.
    run(SD, 3);
    cycle(SD, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_state", 32'(state), 32'd0);
    chk("midreset_count", instr_count, 32'd0);
    chk("midreset_memwrite", 32'(MemWrite), 32'd0);
    chk("midreset_regwrite", 32'(RegWrite), 32'd0);
    pos = 0; m_cnt = 32'd0;
    #1 reset = 1'b0;

    // Randomized traffic; the opcode changes only while fetching.
    for (int i = 0; i < 1500; i++) begin
      if (cur_st() == 0) cur_op = pick_op();
      cycle(cur_op, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
    end

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
